// File: rtl/branch_resolve_buffer_if.sv
// branch_resolve_buffer_if
//   Bundles the dispatch, execute and retire signals of the branch resolve
//   buffer so that they travel as one port.
//
//   Handshake rules:
//     alloc: a branch is accepted on a clock edge where alloc_valid and
//            alloc_ready are both high. alloc_tag is valid alongside
//            alloc_ready. The producer must hold alloc_PC and
//            alloc_pred_next_PC stable while alloc_valid is high.
//     ex:    ex_valid is fire-and-forget. There is no ready signal. Stale or
//            duplicate tags are dropped silently.
//     retire: result_enable and mispredict are one-cycle pulses. The data
//            outputs hold their last values between pulses.
//
//   Modports:
//     master - dispatch/execute side (drives alloc_* and ex_*)
//     slave  - the buffer itself
//
//   Data width comes from the global `XLEN macro (default 32).
`ifndef XLEN
`define XLEN 32
`endif

interface branch_resolve_buffer_if #(
    parameter int BRB_DEPTH = 8,
    parameter int TAG_W     = $clog2(BRB_DEPTH)
);
    logic              alloc_valid;
    logic [`XLEN-1:0]  alloc_PC;
    logic [`XLEN-1:0]  alloc_pred_next_PC;
    logic              alloc_ready;
    logic [TAG_W-1:0]  alloc_tag;
    logic              ex_valid;
    logic [TAG_W-1:0]  ex_tag;
    logic              ex_taken;
    logic [`XLEN-1:0]  ex_target;
    logic              result_enable;
    logic              result_direction;
    logic [`XLEN-1:0]  result_PC;
    logic [`XLEN-1:0]  prev_branch_PC;
    logic              mispredict;
    logic [`XLEN-1:0]  mispredict_PC;
    logic [TAG_W:0]    brb_count;

    modport master (
        output alloc_valid, alloc_PC, alloc_pred_next_PC,
        output ex_valid, ex_tag, ex_taken, ex_target,
        input  alloc_ready, alloc_tag,
        input  result_enable, result_direction, result_PC, prev_branch_PC,
        input  mispredict, mispredict_PC, brb_count
    );

    modport slave (
        input  alloc_valid, alloc_PC, alloc_pred_next_PC,
        input  ex_valid, ex_tag, ex_taken, ex_target,
        output alloc_ready, alloc_tag,
        output result_enable, result_direction, result_PC, prev_branch_PC,
        output mispredict, mispredict_PC, brb_count
    );
endinterface

// File: rtl/branch_resolve_buffer.sv
// branch_resolve_buffer
//   In-order tracking buffer for in-flight predicted branches. Entries are
//   allocated at dispatch and resolved out of order by execute. They retire
//   in program order, at most one per cycle. Each retire produces a
//   registered predictor update. A retire whose actual next PC differs from
//   the predicted one also raises mispredict and flushes every younger entry.
//
//   Ports:
//     clock - system clock
//     reset - asynchronous, active-high reset
//     bus   - branch_resolve_buffer_if.slave, which carries:
//               alloc_*         dispatch handshake
//               ex_*            execute resolve
//               result_*        predictor update
//               prev_branch_PC  predictor update (retired branch's own PC)
//               mispredict*     frontend redirect
//               brb_count       number of occupied entries
//
//   Optional feature: define BRB_BYPASS_EN to let a resolve that hits the
//   unresolved head entry retire in the same cycle.
//
//   Data width comes from the global `XLEN macro (default 32).
`ifndef XLEN
`define XLEN 32
`endif

module branch_resolve_buffer #(
    parameter int BRB_DEPTH = 8,
    parameter int TAG_W     = $clog2(BRB_DEPTH)
) (
    input  logic                    clock,
    input  logic                    reset,
    branch_resolve_buffer_if.slave  bus
);
    localparam int CNT_W = TAG_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(BRB_DEPTH);

    // Entry state. valid/resolved need a reset. The payload does not,
    // because it is only ever read behind a valid bit.
    logic [BRB_DEPTH-1:0] valid_q, valid_d;
    logic [BRB_DEPTH-1:0] resolved_q, resolved_d;
    logic [BRB_DEPTH-1:0] taken_q, taken_d;
    logic [`XLEN-1:0]     pc_q     [BRB_DEPTH];
    logic [`XLEN-1:0]     pc_d     [BRB_DEPTH];
    logic [`XLEN-1:0]     pred_q   [BRB_DEPTH];
    logic [`XLEN-1:0]     pred_d   [BRB_DEPTH];
    logic [`XLEN-1:0]     actual_q [BRB_DEPTH];
    logic [`XLEN-1:0]     actual_d [BRB_DEPTH];

    logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             result_enable_q, result_enable_d;
    logic             result_direction_q, result_direction_d;
    logic [`XLEN-1:0] result_pc_q, result_pc_d;
    logic [`XLEN-1:0] prev_branch_pc_q, prev_branch_pc_d;
    logic             mispredict_q, mispredict_d;
    logic [`XLEN-1:0] mispredict_pc_q, mispredict_pc_d;

    logic             alloc_ready;
    logic             alloc_fire;
    logic             resolve_hit;
    logic             head_hit;
    logic             drain;
    logic             drain_taken;
    logic [`XLEN-1:0] drain_actual;
    logic             misp_now;

    // While a mispredict pulse is out, the frontend is being redirected, so
    // anything presented that cycle is still wrong-path and is refused.
    assign alloc_ready = (count_q != FULL_COUNT) && !mispredict_q;
    assign alloc_fire  = bus.alloc_valid && alloc_ready;
    assign resolve_hit = bus.ex_valid && valid_q[bus.ex_tag] && !resolved_q[bus.ex_tag];

    // Retire selection. The head retires when it is already resolved or,
    // with bypass, when this cycle's resolve targets it.
    always_comb begin
`ifdef BRB_BYPASS_EN
        head_hit = resolve_hit && (bus.ex_tag == head_q);
`else
        head_hit = 1'b0;
`endif
        drain        = (valid_q[head_q] && resolved_q[head_q]) || head_hit;
        drain_taken  = head_hit ? bus.ex_taken  : taken_q[head_q];
        drain_actual = head_hit ? bus.ex_target : actual_q[head_q];
        misp_now     = drain && (drain_actual != pred_q[head_q]);
    end

    always_comb begin
        valid_d    = valid_q;
        resolved_d = resolved_q;
        taken_d    = taken_q;
        pc_d       = pc_q;
        pred_d     = pred_q;
        actual_d   = actual_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q + CNT_W'(alloc_fire) - CNT_W'(drain);

        if (resolve_hit) begin
            resolved_d[bus.ex_tag] = 1'b1;
            taken_d[bus.ex_tag]    = bus.ex_taken;
            actual_d[bus.ex_tag]   = bus.ex_target;
        end

        if (alloc_fire) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
            pc_d[tail_q]       = bus.alloc_PC;
            pred_d[tail_q]     = bus.alloc_pred_next_PC;
            tail_d             = tail_q + TAG_W'(1);
        end

        if (drain) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TAG_W'(1);
        end

        // A mispredict wipes out everything younger, including this
        // cycle's allocation and any resolve that landed on a younger entry.
        if (misp_now) begin
            valid_d    = '0;
            resolved_d = '0;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end

        result_enable_d    = drain;
        result_direction_d = drain ? drain_taken    : result_direction_q;
        result_pc_d        = drain ? drain_actual   : result_pc_q;
        prev_branch_pc_d   = drain ? pc_q[head_q]   : prev_branch_pc_q;
        mispredict_d       = misp_now;
        mispredict_pc_d    = misp_now ? drain_actual : mispredict_pc_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q            <= '0;
            resolved_q         <= '0;
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            result_enable_q    <= 1'b0;
            result_direction_q <= 1'b0;
            result_pc_q        <= '0;
            prev_branch_pc_q   <= '0;
            mispredict_q       <= 1'b0;
            mispredict_pc_q    <= '0;
        end else begin
            valid_q            <= valid_d;
            resolved_q         <= resolved_d;
            head_q             <= head_d;
            tail_q             <= tail_d;
            count_q            <= count_d;
            result_enable_q    <= result_enable_d;
            result_direction_q <= result_direction_d;
            result_pc_q        <= result_pc_d;
            prev_branch_pc_q   <= prev_branch_pc_d;
            mispredict_q       <= mispredict_d;
            mispredict_pc_q    <= mispredict_pc_d;
        end
    end

    always_ff @(posedge clock) begin
        taken_q  <= taken_d;
        pc_q     <= pc_d;
        pred_q   <= pred_d;
        actual_q <= actual_d;
    end

    assign bus.alloc_ready      = alloc_ready;
    assign bus.alloc_tag        = tail_q;
    assign bus.result_enable    = result_enable_q;
    assign bus.result_direction = result_direction_q;
    assign bus.result_PC        = result_pc_q;
    assign bus.prev_branch_PC   = prev_branch_pc_q;
    assign bus.mispredict       = mispredict_q;
    assign bus.mispredict_PC    = mispredict_pc_q;
    assign bus.brb_count        = count_q;
endmodule

// File: tb/tb_branch_resolve_buffer.sv
// tb_branch_resolve_buffer
//   Directed bench for branch_resolve_buffer. Driver tasks issue allocations
//   and resolves. Every retire the bench expects is pushed into exp_q in
//   program order. A monitor pops one entry per result_enable pulse.
`ifndef XLEN
`define XLEN 32
`endif

module tb_branch_resolve_buffer;
  localparam int DEPTH = 8;
  localparam int TW    = $clog2(DEPTH);
  localparam int XW    = `XLEN;
  localparam int EW    = 2 + 3 * XW;   // {mispredict, dir, result_pc, prev_pc, mispredict_pc}

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [EW-1:0] exp_q[$];

  branch_resolve_buffer_if #(.BRB_DEPTH(DEPTH)) bus ();

  branch_resolve_buffer #(.BRB_DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] mk_exp(input logic mp, input logic dir,
                                           input logic [XW-1:0] res_pc,
                                           input logic [XW-1:0] prev_pc);
    logic [XW-1:0] mp_pc;
    mp_pc = mp ? res_pc : '0;
    return {mp, dir, res_pc, prev_pc, mp_pc};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.result_enable) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update: got prev_branch_PC=0x%0h result_PC=0x%0h, expected no update",
                   bus.prev_branch_PC, bus.result_PC);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("upd_mispredict", 64'(bus.mispredict), 64'(e[EW-1]));
          check("upd_direction", 64'(bus.result_direction), 64'(e[EW-2]));
          check("upd_result_PC", 64'(bus.result_PC), 64'(e[3*XW-1:2*XW]));
          check("upd_prev_branch_PC", 64'(bus.prev_branch_PC), 64'(e[2*XW-1:XW]));
          if (e[EW-1])
            check("upd_mispredict_PC", 64'(bus.mispredict_PC), 64'(e[XW-1:0]));
        end
      end else if (bus.mispredict) begin
        checks++;
        errors++;
        $display("FAIL lone_mispredict: got mispredict=1 with result_enable=0, expected both or neither");
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic do_alloc(input logic [XW-1:0] pc, input logic [XW-1:0] pred);
    bus.alloc_valid        = 1'b1;
    bus.alloc_PC           = pc;
    bus.alloc_pred_next_PC = pred;
    @(posedge clock); #1;
    bus.alloc_valid = 1'b0;
  endtask

  task automatic do_resolve(input logic [TW-1:0] tag, input logic taken, input logic [XW-1:0] target);
    bus.ex_valid  = 1'b1;
    bus.ex_tag    = tag;
    bus.ex_taken  = taken;
    bus.ex_target = target;
    @(posedge clock); #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clock); #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [XW-1:0] pc;
    reset                  = 1'b0;
    bus.alloc_valid        = 1'b0;
    bus.alloc_PC           = '0;
    bus.alloc_pred_next_PC = '0;
    bus.ex_valid           = 1'b0;
    bus.ex_tag             = '0;
    bus.ex_taken           = 1'b0;
    bus.ex_target          = '0;

    // Reset state
    #1 reset = 1'b1;
    #10;
    check("rst_result_enable", 64'(bus.result_enable), 64'd0);
    check("rst_mispredict", 64'(bus.mispredict), 64'd0);
    check("rst_brb_count", 64'(bus.brb_count), 64'd0);
    check("rst_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    check("rst_alloc_tag", 64'(bus.alloc_tag), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(1);

    // Correct prediction
    check("cp_tag", 64'(bus.alloc_tag), 64'd0);
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h104, 32'h100));
    do_alloc(32'h100, 32'h104);
    check("cp_count_1", 64'(bus.brb_count), 64'd1);
    do_resolve(0, 1'b0, 32'h104);
    wait_empty("cp_drained", 10);
    idle(1);
    check("cp_count_0", 64'(bus.brb_count), 64'd0);
    reset_pulse();

    // Out-of-order resolve, in-order retire on consecutive cycles
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h14, 32'h10));
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h24, 32'h20));
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h34, 32'h30));
    do_alloc(32'h10, 32'h14);
    do_alloc(32'h20, 32'h24);
    check("ooo_tag2", 64'(bus.alloc_tag), 64'd2);
    do_alloc(32'h30, 32'h34);
    do_resolve(2, 1'b0, 32'h34);
    do_resolve(1, 1'b0, 32'h24);
    do_resolve(0, 1'b0, 32'h14);
`ifndef BRB_BYPASS_EN
    @(negedge clock);
    check("ooo_gap", 64'(bus.result_enable), 64'd0);
`endif
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("ooo_consecutive", 64'(bus.result_enable), 64'd1);
    end
    @(negedge clock);
    check("ooo_done", 64'(bus.result_enable), 64'd0);
    @(posedge clock); #1;
    check("ooo_count", 64'(bus.brb_count), 64'd0);
    reset_pulse();

    // Mispredict flush
    exp_q.push_back(mk_exp(1'b1, 1'b1, 32'h400, 32'h200));
    do_alloc(32'h200, 32'h204);
    do_alloc(32'h300, 32'h304);
    do_resolve(1, 1'b0, 32'h304);
    do_resolve(0, 1'b1, 32'h400);
    // This allocation lands in the retire cycle and must be discarded.
    do_alloc(32'h500, 32'h504);
    check("mp_alloc_blocked", 64'(bus.alloc_ready), 64'd0);
    idle(1);
    check("mp_count", 64'(bus.brb_count), 64'd0);
    check("mp_next_tag", 64'(bus.alloc_tag), 64'd0);
    check("mp_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    wait_empty("mp_drained", 5);
    idle(4);
    reset_pulse();

    // Full and wrap
    for (int i = 0; i < DEPTH; i++) begin
      pc = 32'h1000 + 32'(i) * 32'h10;
      exp_q.push_back(mk_exp(1'b0, 1'b0, pc + 32'h4, pc));
      do_alloc(pc, pc + 32'h4);
    end
    check("full_ready", 64'(bus.alloc_ready), 64'd0);
    check("full_count", 64'(bus.brb_count), 64'd8);
    // Extra allocation held across the resolve and the retire cycle.
    bus.alloc_valid        = 1'b1;
    bus.alloc_PC           = 32'hdead;
    bus.alloc_pred_next_PC = 32'hbeef;
    do_resolve(0, 1'b0, 32'h1004);
    @(posedge clock); #1;
    bus.alloc_valid = 1'b0;
    check("wrap_count", 64'(bus.brb_count), 64'd7);
    check("wrap_ready", 64'(bus.alloc_ready), 64'd1);
    check("wrap_tag", 64'(bus.alloc_tag), 64'd0);
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h2004, 32'h2000));
    do_alloc(32'h2000, 32'h2004);
    for (int i = 1; i < DEPTH; i++) begin
      pc = 32'h1000 + 32'(i) * 32'h10;
      do_resolve(TW'(i), 1'b0, pc + 32'h4);
    end
    do_resolve(0, 1'b0, 32'h2004);
    wait_empty("wrap_drained", 40);
    idle(2);
    check("wrap_count_0", 64'(bus.brb_count), 64'd0);

    // Async reset mid-stream: 4 entries, 2 resolved but not at the head.
    // The buffer is empty here with head = tail = 1, so these get tags 1..4.
    for (int i = 0; i < 4; i++) begin
      pc = 32'h40 + 32'(i) * 32'h10;
      do_alloc(pc, pc + 32'h4);
    end
    do_resolve(2, 1'b0, 32'h54);
    do_resolve(3, 1'b0, 32'h64);
    check("ar_count_pre", 64'(bus.brb_count), 64'd4);
    reset = 1'b1;
    #1;
    check("ar_count", 64'(bus.brb_count), 64'd0);
    check("ar_result_enable", 64'(bus.result_enable), 64'd0);
    check("ar_prev_pc", 64'(bus.prev_branch_PC), 64'd0);
    check("ar_result_pc", 64'(bus.result_PC), 64'd0);
    check("ar_alloc_tag", 64'(bus.alloc_tag), 64'd0);
    check("ar_alloc_ready", 64'(bus.alloc_ready), 64'd1);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    for (int i = 1; i <= 4; i++) begin
      do_resolve(TW'(i), 1'b0, 32'h0);
    end
    do_resolve(0, 1'b1, 32'h0);
    idle(5);
    check("ar_count_post", 64'(bus.brb_count), 64'd0);
    check("ar_tag_post", 64'(bus.alloc_tag), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
